// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - cache-side types: arbiter FSM states and service history
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DGRANT = 2'b01,
    IGRANT = 2'b10
  } arbstate_t;

  typedef enum logic {
    SRV_D = 1'b0,
    SRV_I = 1'b1
  } srv_t;

endpackage

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU-side types: machine word and RAM status
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - cache request and RAM signals seen by the memory arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  import cpu_types_pkg::*;

  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic [DATA_W-1:0] iload;
  logic              iwait;

  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic [DATA_W-1:0] dload;
  logic              dwait;

  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  ramstate_t         ramstate;
  logic              ram_err;

  // the arbiter side
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, ram_err
  );

  // the caches and RAM as seen from outside the arbiter
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, ram_err
  );

endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter granting one icache/dcache word at a time
module mem_arbiter
  import cpu_types_pkg::*;
  import cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus
);

  arbstate_t         state;
  srv_t              last_srv;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              req_wen;
  logic              ram_err_q;

  logic d_req;
  logic i_req;
  logic granted_active;
  logic access;
  logic done;

  assign d_req  = bus.dREN | bus.dWEN;
  assign i_req  = bus.iREN;
  assign access = (bus.ramstate == ACCESS);

  // a granted cache that lets go of its request aborts the access
  always_comb begin
    granted_active = 1'b0;
    case (state)
      DGRANT:  granted_active = d_req;
      IGRANT:  granted_active = i_req;
      default: granted_active = 1'b0;
    endcase
  end

  assign done = granted_active & access;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      last_srv  <= SRV_I;
      req_addr  <= '0;
      req_data  <= '0;
      req_wen   <= 1'b0;
      ram_err_q <= 1'b0;
    end else begin
      if ((state != IDLE) && (bus.ramstate == ERROR))
        ram_err_q <= 1'b1;

      case (state)
        IDLE: begin
          // on contention the cache that was not served last wins
          if (d_req && (!i_req || (last_srv == SRV_I))) begin
            state    <= DGRANT;
            req_addr <= bus.daddr;
            req_data <= bus.dstore;
            req_wen  <= bus.dWEN;
          end else if (i_req) begin
            state    <= IGRANT;
            req_addr <= bus.iaddr;
            req_data <= '0;
            req_wen  <= 1'b0;
          end
        end
        DGRANT, IGRANT: begin
          if (!granted_active) begin
            state <= IDLE;
          end else if (access) begin
            state    <= IDLE;
            last_srv <= (state == DGRANT) ? SRV_D : SRV_I;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.ramREN   = granted_active & ~req_wen;
    bus.ramWEN   = granted_active &  req_wen;
    bus.ramaddr  = req_addr;
    bus.ramstore = req_data;
    bus.ram_err  = ram_err_q;

    bus.dwait = ~((state == DGRANT) & done);
    bus.iwait = ~((state == IGRANT) & done);
    bus.dload = ((state == DGRANT) && done && !req_wen) ? bus.ramload : '0;
    bus.iload = ((state == IGRANT) && done) ? bus.ramload : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a latency-programmable RAM
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int   total  = 0;
  int   passed = 0;
  int   cyc    = 0;
  int   lat    = 0;
  logic err_mode = 1'b0;
  int   ram_cnt;

  function automatic word_t data_of(input word_t a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h0F0F1234;
  endfunction

  // RAM: ACCESS once a strobe has been held for lat cycles
  always @(posedge CLK or negedge nRST) begin
    if (!nRST)
      ram_cnt <= 0;
    else if ((bus.ramREN || bus.ramWEN) && (bus.ramstate != ACCESS))
      ram_cnt <= ram_cnt + 1;
    else
      ram_cnt <= 0;
  end

  always_comb begin
    bus.ramstate = FREE;
    if (bus.ramREN || bus.ramWEN)
      bus.ramstate = err_mode ? ERROR : ((ram_cnt >= lat) ? ACCESS : BUSY);
    bus.ramload = data_of(bus.ramaddr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic next();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    bus.iREN = 1'b0; bus.iaddr = '0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int    seq [6];
  int    tms [6];
  int    got;
  int    both_low;
  int    f_who [3];
  word_t f_addr [3];
  word_t f_load [3];
  int    adj;
  logic  lowprev, dprev, iprev;

  // reference model: transaction-level view of who owns RAM and until when
  int    m_owner, m_last, m_comp, m_free;
  word_t m_addr, m_data;
  logic  m_wen, m_cpl;
  logic  d_pend, i_pend, d_done, i_done, w;
  int    n_cpl;

  initial begin
    idle_inputs();
    nRST = 1'b0;
    smp(); smp();
    chk("rst_iwait",    bus.iwait,    1);
    chk("rst_dwait",    bus.dwait,    1);
    chk("rst_ramREN",   bus.ramREN,   0);
    chk("rst_ramWEN",   bus.ramWEN,   0);
    chk("rst_ramaddr",  bus.ramaddr,  0);
    chk("rst_ramstore", bus.ramstore, 0);
    chk("rst_iload",    bus.iload,    0);
    chk("rst_dload",    bus.dload,    0);
    chk("rst_ram_err",  bus.ram_err,  0);
    nRST = 1'b1;

    // contention: both hold requests, strict alternation starting with dcache
    lat = 0;
    foreach (seq[k]) begin seq[k] = 0; tms[k] = 0; end
    next();
    bus.iREN = 1'b1; bus.iaddr = 32'h1000;
    bus.dREN = 1'b1; bus.daddr = 32'h2000;
    smp();
    got = 0; both_low = 0;
    for (int k = 0; k < 40 && got < 6; k++) begin
      next(); smp();
      if (!bus.dwait && !bus.iwait) both_low++;
      else if (!bus.dwait) begin seq[got] = 1; tms[got] = cyc; got++; end
      else if (!bus.iwait) begin seq[got] = 2; tms[got] = cyc; got++; end
    end
    chk("cont_count", got, 6);
    chk("cont_both_low", both_low, 0);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("cont_grant%0d", k), seq[k], (k % 2 == 0) ? 1 : 2);
      chk($sformatf("cont_time%0d", k), tms[k] - tms[0], 2 * k);
    end
    next(); idle_inputs(); smp();

    // two-word fill interleaved with a held icache read
    lat = 1;
    next();
    bus.iREN = 1'b1; bus.iaddr = 32'h200;
    bus.dREN = 1'b1; bus.daddr = 32'h80;
    smp();
    got = 0; adj = 0; lowprev = 1'b0; dprev = 1'b0; iprev = 1'b0;
    foreach (f_who[k]) begin f_who[k] = 0; f_addr[k] = '0; f_load[k] = '0; end
    for (int k = 0; k < 40 && got < 3; k++) begin
      next();
      if (dprev) begin
        if (bus.daddr == 32'h80) bus.daddr = 32'h84;
        else bus.dREN = 1'b0;
      end
      if (iprev) bus.iREN = 1'b0;
      smp();
      dprev = !bus.dwait;
      iprev = !bus.iwait;
      if (dprev || iprev) begin
        if (lowprev) adj++;
        f_who[got]  = dprev ? 1 : 2;
        f_addr[got] = bus.ramaddr;
        f_load[got] = dprev ? bus.dload : bus.iload;
        got++;
      end
      lowprev = dprev || iprev;
    end
    chk("fill_count", got, 3);
    chk("fill_adjacent_low", adj, 0);
    chk("fill_who0", f_who[0], 1);  chk("fill_addr0", f_addr[0], 32'h80);
    chk("fill_who1", f_who[1], 2);  chk("fill_addr1", f_addr[1], 32'h200);
    chk("fill_who2", f_who[2], 1);  chk("fill_addr2", f_addr[2], 32'h84);
    chk("fill_load0", f_load[0], data_of(32'h80));
    chk("fill_load1", f_load[1], data_of(32'h200));
    chk("fill_load2", f_load[2], data_of(32'h84));
    next(); idle_inputs(); smp();

    // single dcache read with RAM latency 2
    lat = 2;
    next(); bus.dREN = 1'b1; bus.daddr = 32'h40; smp();
    chk("rd_c0_ren", bus.ramREN, 0);
    next(); smp();
    chk("rd_c1_ren", bus.ramREN, 1);
    chk("rd_c1_addr", bus.ramaddr, 32'h40);
    chk("rd_c1_dwait", bus.dwait, 1);
    next(); smp();
    chk("rd_c2_dwait", bus.dwait, 1);
    next(); smp();
    chk("rd_c3_dwait", bus.dwait, 0);
    chk("rd_c3_dload", bus.dload, 32'hDEADBEEF);
    chk("rd_c3_iwait", bus.iwait, 1);
    next(); bus.dREN = 1'b0; smp();
    chk("rd_c4_ren", bus.ramREN, 0);
    chk("rd_c4_dwait", bus.dwait, 1);

    // write: latched data survives a change of dstore
    lat = 1;
    next();
    bus.dWEN = 1'b1; bus.dREN = 1'b1; bus.daddr = 32'h3100; bus.dstore = 32'h12;
    smp();
    next(); bus.dstore = 32'h99; smp();
    chk("wr_wen", bus.ramWEN, 1);
    chk("wr_ren", bus.ramREN, 0);
    chk("wr_addr", bus.ramaddr, 32'h3100);
    chk("wr_store", bus.ramstore, 32'h12);
    next(); smp();
    chk("wr_dwait", bus.dwait, 0);
    chk("wr_dload", bus.dload, 0);
    chk("wr_store_hold", bus.ramstore, 32'h12);
    next(); idle_inputs(); smp();

    // abort: dcache drops while BUSY, pending icache then gets the RAM
    lat = 5;
    next(); bus.dREN = 1'b1; bus.daddr = 32'h50; smp();
    next(); smp();
    chk("ab_ren_on", bus.ramREN, 1);
    next(); bus.iREN = 1'b1; bus.iaddr = 32'h300; smp();
    chk("ab_iwait_pending", bus.iwait, 1);
    next(); bus.dREN = 1'b0; smp();
    chk("ab_ren_drop", bus.ramREN, 0);
    chk("ab_dwait", bus.dwait, 1);
    next(); lat = 0; smp();
    chk("ab_idle_ren", bus.ramREN, 0);
    next(); smp();
    chk("ab_igrant_ren", bus.ramREN, 1);
    chk("ab_igrant_addr", bus.ramaddr, 32'h300);
    chk("ab_iwait", bus.iwait, 0);
    chk("ab_iload", bus.iload, data_of(32'h300));
    next(); idle_inputs(); smp();

    // ERROR while granted, then asynchronous reset mid-grant
    lat = 20;
    next(); bus.dREN = 1'b1; bus.daddr = 32'h60; smp();
    next(); smp();
    next(); err_mode = 1'b1; smp();
    chk("err_dwait", bus.dwait, 1);
    chk("err_not_yet", bus.ram_err, 0);
    next(); err_mode = 1'b0; smp();
    chk("err_sticky", bus.ram_err, 1);
    chk("err_dwait2", bus.dwait, 1);
    chk("err_ren_held", bus.ramREN, 1);
    @(posedge CLK); #2;
    nRST = 1'b0;
    #1;
    chk("arst_ren", bus.ramREN, 0);
    chk("arst_wen", bus.ramWEN, 0);
    chk("arst_err", bus.ram_err, 0);
    chk("arst_addr", bus.ramaddr, 0);
    chk("arst_dwait", bus.dwait, 1);
    idle_inputs();
    smp();
    nRST = 1'b1;

    // randomized traffic against the transaction-level model
    for (int seg = 0; seg < 3; seg++) begin
      nRST = 1'b0; idle_inputs(); smp(); nRST = 1'b1;
      lat = $urandom_range(0, 3);
      m_owner = 0; m_last = 2; m_comp = 0; m_free = 0;
      m_addr = '0; m_data = '0; m_wen = 1'b0;
      d_pend = 1'b0; i_pend = 1'b0; d_done = 1'b0; i_done = 1'b0;
      n_cpl = 0;
      for (int k = 0; k < 150; k++) begin
        next();
        if (d_done) begin d_pend = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0; end
        if (i_done) begin i_pend = 1'b0; bus.iREN = 1'b0; end
        if (!d_pend && $urandom_range(0, 1) == 1) begin
          d_pend = 1'b1;
          w = 1'($urandom_range(0, 1));
          bus.dWEN = w;
          bus.dREN = !w || ($urandom_range(0, 1) == 1);
          bus.daddr = $urandom & 32'hFFFF_FFFC;
          bus.dstore = $urandom;
        end else if (d_pend && $urandom_range(0, 3) == 0) begin
          bus.dstore = $urandom;
        end
        if (!i_pend && $urandom_range(0, 1) == 1) begin
          i_pend = 1'b1;
          bus.iREN = 1'b1;
          bus.iaddr = $urandom & 32'hFFFF_FFFC;
        end
        smp();

        m_cpl = (m_owner != 0) && (cyc == m_comp);
        chk("rnd_dwait", bus.dwait, 32'(!(m_owner == 1 && m_cpl)));
        chk("rnd_iwait", bus.iwait, 32'(!(m_owner == 2 && m_cpl)));
        chk("rnd_ramREN", bus.ramREN, 32'(m_owner != 0 && !m_wen));
        chk("rnd_ramWEN", bus.ramWEN, 32'(m_owner != 0 && m_wen));
        if (m_owner != 0) chk("rnd_ramaddr", bus.ramaddr, m_addr);
        if (m_owner != 0 && m_wen) chk("rnd_ramstore", bus.ramstore, m_data);
        chk("rnd_dload", bus.dload, (m_owner == 1 && m_cpl && !m_wen) ? data_of(m_addr) : 32'h0);
        chk("rnd_iload", bus.iload, (m_owner == 2 && m_cpl) ? data_of(m_addr) : 32'h0);

        d_done = !bus.dwait;
        i_done = !bus.iwait;
        if (m_cpl) begin
          m_last = m_owner; m_owner = 0; m_free = cyc + 1; n_cpl++;
        end
        if (m_owner == 0 && cyc >= m_free) begin
          if ((bus.dREN || bus.dWEN) && (!bus.iREN || m_last == 2)) begin
            m_owner = 1; m_addr = bus.daddr; m_data = bus.dstore; m_wen = bus.dWEN;
            m_comp = cyc + 1 + lat;
          end else if (bus.iREN) begin
            m_owner = 2; m_addr = bus.iaddr; m_data = '0; m_wen = 1'b0;
            m_comp = cyc + 1 + lat;
          end
        end
      end
      chk($sformatf("rnd_seg%0d_progress", seg), 32'(n_cpl > 10), 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
